// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive scheduler: FSM states,
// legal prescale values, reset defaults and counter widths.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam logic [5:0] PRESCALE_8   = 6'd8;
  localparam logic [5:0] PRESCALE_16  = 6'd16;
  localparam logic [5:0] PRESCALE_32  = 6'd32;
  localparam logic [5:0] PRESCALE_DEF = PRESCALE_8;

  localparam int ERR_CNT_W  = 8;
  localparam int FIFO_CNT_W = 5;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// Synchronous byte FIFO; write-to-head latency 1 cycle; a push while full is
// dropped (ovf_o pulses) unless a pop happens in the same cycle.
module uart_rx_byte_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [7:0]            push_dat_i,
  input  logic                  pop_i,
  output logic [7:0]            head_dat_o,
  output logic                  head_vld_o,
  output logic                  full_o,
  output logic                  ovf_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]            mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  empty, full, pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FIFO_CNT_W'(DEPTH));
  assign pop_ok  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_i && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_vld_o = !empty;
  assign head_dat_o = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign full_o     = full;
  assign ovf_o      = push_i && full && !pop_ok;
  assign count_o    = count_q;

endmodule

// File: rtl/uart_rx_sched_ctrl.sv
// UART RX scheduler: commits prescale/parity only between frames (drain, commit,
// settle), buffers bytes in a FIFO. Error counters exist only with UART_RX_ERR_CNT_EN.
module uart_rx_sched_ctrl
  import uart_rx_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         SETTLE_CYC   = 2,
  parameter logic [5:0] DEF_PRESCALE = PRESCALE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [5:0] cfg_prescale,
  input  logic       cfg_par_en,
  input  logic       cfg_par_typ,
  output logic       cfg_ack,
  output logic       cfg_err,
  input  logic       rx_busy,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_p_data,
  input  logic       rx_par_err,
  input  logic       rx_stp_err,
  output logic       rx_en,
  output logic [5:0] prescale,
  output logic       par_en,
  output logic       par_typ,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [4:0] fifo_count,
  output logic       overflow,
  input  logic       clr_stat,
  output logic [7:0] par_err_cnt,
  output logic [7:0] stp_err_cnt
);

  state_e     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic       redo_q, redo_d;
  logic [5:0] pend_prescale_q, live_prescale_q;
  logic       pend_par_en_q, pend_par_typ_q, live_par_en_q, live_par_typ_q;
  logic       cfg_ack_q, cfg_err_q, ovf_q, fifo_ovf;
  logic       wr_legal, wr_bad;

  assign wr_legal = cfg_wr && prescale_legal(cfg_prescale);
  assign wr_bad   = cfg_wr && !prescale_legal(cfg_prescale);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    redo_d   = redo_q;
    rx_en    = 1'b1;
    case (state_q)
      RUN:   if (wr_legal) state_d = DRAIN;
      DRAIN: if (!rx_busy && !rx_data_valid) state_d = COMMIT;
      COMMIT: begin
        rx_en    = 1'b0;
        state_d  = SETTLE;
        settle_d = 4'(SETTLE_CYC - 1);
        if (wr_legal) redo_d = 1'b1;
      end
      SETTLE: begin
        rx_en = 1'b0;
        if (wr_legal) redo_d = 1'b1;
        // A write accepted while RX was held gets its own drain/commit pass.
        if (settle_q == 4'd0) begin
          if (redo_q || wr_legal) begin
            state_d = DRAIN;
            redo_d  = 1'b0;
          end else begin
            state_d = RUN;
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      settle_q        <= '0;
      redo_q          <= 1'b0;
      pend_prescale_q <= DEF_PRESCALE;
      pend_par_en_q   <= 1'b0;
      pend_par_typ_q  <= 1'b0;
      live_prescale_q <= DEF_PRESCALE;
      live_par_en_q   <= 1'b0;
      live_par_typ_q  <= 1'b0;
      cfg_ack_q       <= 1'b0;
      cfg_err_q       <= 1'b0;
      ovf_q           <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      redo_q    <= redo_d;
      cfg_ack_q <= (state_q == COMMIT);
      cfg_err_q <= wr_bad;
      if (wr_legal) begin
        pend_prescale_q <= cfg_prescale;
        pend_par_en_q   <= cfg_par_en;
        pend_par_typ_q  <= cfg_par_typ;
      end
      if (state_q == COMMIT) begin
        live_prescale_q <= pend_prescale_q;
        live_par_en_q   <= pend_par_en_q;
        live_par_typ_q  <= pend_par_typ_q;
      end
      if (clr_stat)      ovf_q <= 1'b0;
      else if (fifo_ovf) ovf_q <= 1'b1;
    end
  end

  uart_rx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rx_data_valid),
    .push_dat_i (rx_p_data),
    .pop_i      (out_ready),
    .head_dat_o (out_data),
    .head_vld_o (out_valid),
    .full_o     (),
    .ovf_o      (fifo_ovf),
    .count_o    (fifo_count)
  );

`ifdef UART_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] par_cnt_q, stp_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_stat) begin
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else begin
      if (rx_par_err && (par_cnt_q != '1)) par_cnt_q <= par_cnt_q + ERR_CNT_W'(1);
      if (rx_stp_err && (stp_cnt_q != '1)) stp_cnt_q <= stp_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;
`else
  logic unused_err;
  assign unused_err  = rx_par_err | rx_stp_err;
  assign par_err_cnt = '0;
  assign stp_err_cnt = '0;
`endif

  assign cfg_ack  = cfg_ack_q;
  assign cfg_err  = cfg_err_q;
  assign prescale = live_prescale_q;
  assign par_en   = live_par_en_q;
  assign par_typ  = live_par_typ_q;
  assign overflow = ovf_q;

endmodule
